run_sequencer: RTL

Host-side run controller that sits directly upstream of `TopLevel`. It preloads the core's data memory from a byte-write command stream, then holds `start` high until preload completes and releases it to launch the program. It waits for `halt` or a timeout, then streams a window of result bytes back out of data memory. It replaces bench-side hierarchical pokes, so the same preload/readback path works in synthesis and on hardware.

---
 rtl/run_seq_pkg.sv | 19 +
 rtl/run_timer.sv | 33 +++
 rtl/run_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/run_seq_pkg.sv
// Shared types and default constants for the run sequencer and its cycle timer.
package run_seq_pkg;

  localparam int unsigned DEF_AW       = 8;
  localparam int unsigned DEF_DW       = 8;
  localparam int unsigned DEF_RES_BASE = 4;
  localparam int unsigned DEF_RES_LEN  = 3;
  localparam int unsigned DEF_TIMEOUT  = 65535;
  localparam int unsigned CYC_W        = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_RUN    = 3'd3,
    ST_DUMP   = 3'd4
  } run_state_t;

endpackage

// File: rtl/run_timer.sv
// Run-cycle counter: clears on launch, counts enabled cycles, saturates at TIMEOUT.
module run_timer
  import run_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CYC_W-1:0] o_cycles,
  output logic             o_hit_c
);

  localparam logic [CYC_W-1:0] LIMIT = CYC_W'(TIMEOUT);

  logic [CYC_W-1:0] r_count;

  // Saturating counter; clear takes priority over counting
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != LIMIT)) begin
      r_count <= r_count + CYC_W'(1);
    end
  end

  assign o_cycles = r_count;
  assign o_hit_c  = (r_count == LIMIT);

endmodule

// File: rtl/run_sequencer.sv
// Host-side run controller: preloads data memory, launches the core, waits for
// halt or timeout, then streams a window of result bytes out of data memory.
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int unsigned AW       = DEF_AW,
  parameter int unsigned DW       = DEF_DW,
  parameter int unsigned RES_BASE = DEF_RES_BASE,
  parameter int unsigned RES_LEN  = DEF_RES_LEN,
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [DW-1:0]    cmd_data,
  input  logic             cmd_last,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata,
  output logic             start,
  input  logic             halt,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [DW-1:0]    res_data,
  output logic [AW-1:0]    res_addr,
  output logic             res_last,
  output logic [CYC_W-1:0] cycles,
  output logic             timeout,
  output logic             busy
);

  localparam logic [AW-1:0] BASE     = AW'(RES_BASE);
  localparam logic [AW-1:0] LAST_IDX = AW'(RES_LEN - 1);

  run_state_t       r_state;
  logic             r_cmd_ready;
  logic             r_start;
  logic             r_mem_we;
  logic [AW-1:0]    r_mem_addr;
  logic [DW-1:0]    r_mem_wdata;
  logic             r_res_valid;
  logic [AW-1:0]    r_res_addr;
  logic             r_res_last;
  logic             r_timeout;
  logic             r_busy;
  logic [AW-1:0]    r_idx;

  logic             w_accept;
  logic             w_res_fire;
  logic             w_clr;
  logic             w_en;
  logic             w_hit;
  logic [CYC_W-1:0] w_cycles;

  assign w_accept   = cmd_valid && r_cmd_ready;
  assign w_res_fire = r_res_valid && res_ready;
  assign w_clr      = (r_state == ST_LAUNCH);
  assign w_en       = (r_state == ST_RUN) && !halt;

  run_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .CLK      (CLK),
    .rst_n    (rst_n),
    .i_clr    (w_clr),
    .i_en     (w_en),
    .o_cycles (w_cycles),
    .o_hit_c  (w_hit)
  );

  // Sequencer FSM with registered preload, launch, run and dump outputs
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b1;
      r_start     <= 1'b1;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_res_valid <= 1'b0;
      r_res_addr  <= '0;
      r_res_last  <= 1'b0;
      r_timeout   <= 1'b0;
      r_busy      <= 1'b0;
      r_idx       <= '0;
    end else begin
      // memory write is a single-cycle pulse per accepted command
      r_mem_we <= 1'b0;
      case (r_state)
        ST_IDLE, ST_LOAD: begin
          if (w_accept) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= cmd_addr;
            r_mem_wdata <= cmd_data;
            r_busy      <= 1'b1;
            if (cmd_last) begin
              r_state     <= ST_LAUNCH;
              r_cmd_ready <= 1'b0;
            end else begin
              r_state <= ST_LOAD;
            end
          end
        end
        ST_LAUNCH: begin
          // final preload write lands this cycle; release the core next
          r_state   <= ST_RUN;
          r_start   <= 1'b0;
          r_timeout <= 1'b0;
        end
        ST_RUN: begin
          if (halt || w_hit) begin
            // halt wins over a simultaneous timeout
            r_timeout   <= !halt;
            r_state     <= ST_DUMP;
            r_start     <= 1'b1;
            r_mem_addr  <= BASE;
            r_res_addr  <= BASE;
            r_res_valid <= 1'b1;
            r_idx       <= '0;
            r_res_last  <= (LAST_IDX == '0);
          end
        end
        ST_DUMP: begin
          if (w_res_fire) begin
            if (r_res_last) begin
              r_state     <= ST_IDLE;
              r_res_valid <= 1'b0;
              r_res_last  <= 1'b0;
              r_cmd_ready <= 1'b1;
              r_busy      <= 1'b0;
            end else begin
              r_idx      <= r_idx + AW'(1);
              r_mem_addr <= r_mem_addr + AW'(1);
              r_res_addr <= r_res_addr + AW'(1);
              r_res_last <= ((r_idx + AW'(1)) == LAST_IDX);
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cmd_ready <= 1'b1;
          r_start     <= 1'b1;
          r_res_valid <= 1'b0;
          r_res_last  <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign start     = r_start;
  assign res_valid = r_res_valid;
  assign res_data  = mem_rdata;
  assign res_addr  = r_res_addr;
  assign res_last  = r_res_last;
  assign cycles    = w_cycles;
  assign timeout   = r_timeout;
  assign busy      = r_busy;

endmodule
